// File: rtl/ag_sram_fifo_if.sv
// Bus bundle for the SRAM-backed byte FIFO: control, write/read handshakes and status.
interface ag_sram_fifo_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic              clear;
   logic              mode;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic [ADDR_W:0]   count;
   logic              empty;
   logic              full;
   logic              almost_full;
   logic              drop;
   logic              overflow;
   logic              underflow;

   modport master (
      output clear, mode, wr_en, wr_data, rd_en,
      input  rd_data, rd_valid, count, empty, full, almost_full, drop, overflow, underflow
   );

   modport slave (
      input  clear, mode, wr_en, wr_data, rd_en,
      output rd_data, rd_valid, count, empty, full, almost_full, drop, overflow, underflow
   );
endinterface

// File: rtl/ag_sram_fifo.sv
// Circular FIFO over a single-clock memory with STREAM/OVERWRITE full handling,
// almost-full threshold and sticky overflow/underflow flags.
module ag_sram_fifo #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 4,
   parameter int AF_LEVEL = 12
) (
   input logic            clk,
   input logic            n_rst,
   ag_sram_fifo_if.slave  bus
);
   localparam int              DEPTH   = 2**ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W:0] AF_C    = AF_LEVEL[ADDR_W:0];

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              drop_q, drop_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;

   logic empty, full, rd_acc, wr_acc, ovr_drop, mem_we;

   always_comb begin
      empty    = (count_q == '0);
      full     = (count_q == DEPTH_C);
      rd_acc   = bus.rd_en && !empty;
      wr_acc   = bus.wr_en && (!full || bus.mode);
      // Overwrite of a full buffer with no read retires the oldest word instead.
      ovr_drop = bus.wr_en && full && bus.mode && !rd_acc;
      mem_we   = wr_acc && !bus.clear;

      wr_ptr_d   = wr_ptr_q + ADDR_W'(wr_acc);
      rd_ptr_d   = rd_ptr_q + ADDR_W'(rd_acc || ovr_drop);
      rd_data_d  = rd_acc ? mem_q[rd_ptr_q] : rd_data_q;
      rd_valid_d = rd_acc;
      drop_d     = ovr_drop;
      ovf_d      = ovf_q | (bus.wr_en && full && !bus.mode);
      udf_d      = udf_q | (bus.rd_en && empty);

      count_d = count_q;
      if (wr_acc && !rd_acc && !full)
         count_d = count_q + (ADDR_W+1)'(1);
      else if (rd_acc && !wr_acc)
         count_d = count_q - (ADDR_W+1)'(1);

      if (bus.clear) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         rd_data_d  = rd_data_q;
         rd_valid_d = 1'b0;
         drop_d     = 1'b0;
         ovf_d      = 1'b0;
         udf_d      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (n_rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         drop_q     <= 1'b0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         drop_q     <= drop_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
      end
   end

   // Storage is not reset; the read above samples the old word before this write lands.
   always_ff @(posedge clk) begin
      if (!n_rst && mem_we)
         mem_q[wr_ptr_q] <= bus.wr_data;
   end

   assign bus.rd_data     = rd_data_q;
   assign bus.rd_valid    = rd_valid_q;
   assign bus.count       = count_q;
   assign bus.empty       = empty;
   assign bus.full        = full;
   assign bus.almost_full = (count_q >= AF_C);
   assign bus.drop        = drop_q;
   assign bus.overflow    = ovf_q;
   assign bus.underflow   = udf_q;
endmodule

// File: tb/tb_ag_sram_fifo.sv
// Directed scoreboard bench for ag_sram_fifo with DEPTH=4, AF_LEVEL=3.
module tb_ag_sram_fifo;
   logic clk;
   logic n_rst;
   int   total;
   int   bad;
   logic [7:0] exp_q [$];

   ag_sram_fifo_if #(.DATA_W(8), .ADDR_W(2)) bus ();

   ag_sram_fifo #(.DATA_W(8), .ADDR_W(2), .AF_LEVEL(3)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   // One clocked operation; exp_rd >= 0 queues the word the read must return.
   task automatic op(input bit wr, input int wd, input bit rd, input int exp_rd,
                     input bit clr = 1'b0, input bit rst = 1'b0);
      bus.wr_en   = wr;
      bus.wr_data = wd[7:0];
      bus.rd_en   = rd;
      bus.clear   = clr;
      n_rst       = rst;
      if (exp_rd >= 0) exp_q.push_back(exp_rd[7:0]);
      @(posedge clk);
      #1;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      bus.clear = 1'b0;
      n_rst     = 1'b0;
   endtask

   // Monitor: every rd_valid pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!n_rst && bus.rd_valid) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got rd_data 0x%0h with nothing expected", bus.rd_data);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (bus.rd_data != e) begin
               bad++;
               $display("FAIL sb_rd_data: got 0x%0h expected 0x%0h", bus.rd_data, e);
            end
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      total = 0;
      bad   = 0;
      bus.clear = 1'b0; bus.mode = 1'b0; bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_en = 1'b0;
      n_rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      n_rst = 1'b0;

      chk("rst_count", int'(bus.count), 0);
      chk("rst_empty", int'(bus.empty), 1);
      chk("rst_full", int'(bus.full), 0);
      chk("rst_af", int'(bus.almost_full), 0);
      chk("rst_rd_data", int'(bus.rd_data), 0);
      chk("rst_rd_valid", int'(bus.rd_valid), 0);
      chk("rst_flags", int'({bus.drop, bus.overflow, bus.underflow}), 0);

      // basic write/read
      op(1, 8'h11, 0, -1); op(1, 8'h22, 0, -1); op(1, 8'h33, 0, -1);
      chk("basic_count", int'(bus.count), 3);
      chk("basic_af", int'(bus.almost_full), 1);
      chk("basic_full", int'(bus.full), 0);
      op(0, 0, 1, 8'h11);
      chk("lat1_valid", int'(bus.rd_valid), 1);
      op(0, 0, 1, 8'h22); op(0, 0, 1, 8'h33);
      chk("basic_empty", int'(bus.empty), 1);

      // STREAM full
      bus.mode = 1'b0;
      for (int i = 0; i < 4; i++) op(1, 8'hA0 + i, 0, -1);
      op(1, 8'hA4, 0, -1);
      chk("strm_full", int'(bus.full), 1);
      chk("strm_ovf", int'(bus.overflow), 1);
      chk("strm_count", int'(bus.count), 4);
      for (int i = 0; i < 4; i++) op(0, 0, 1, 8'hA0 + i);
      chk("strm_empty", int'(bus.empty), 1);
      op(0, 0, 0, -1, 1'b1);
      chk("clr_ovf", int'(bus.overflow), 0);
      chk("clr_holds_rd_data", int'(bus.rd_data), 8'hA3);

      // OVERWRITE full
      bus.mode = 1'b1;
      for (int i = 0; i < 4; i++) op(1, 8'hB0 + i, 0, -1);
      op(1, 8'hB4, 0, -1);
      chk("ovw_drop", int'(bus.drop), 1);
      chk("ovw_count", int'(bus.count), 4);
      op(0, 0, 0, -1);
      chk("ovw_drop_pulse", int'(bus.drop), 0);
      for (int i = 1; i < 5; i++) op(0, 0, 1, 8'hB0 + i);

      // wrap with simultaneous read/write at count=2
      op(1, 8'hC0, 0, -1); op(1, 8'hC1, 0, -1);
      for (int i = 0; i < 6; i++) op(1, 8'hC2 + i, 1, 8'hC0 + i);
      chk("wrap_count", int'(bus.count), 2);
      op(0, 0, 1, 8'hC6); op(0, 0, 1, 8'hC7);
      chk("wrap_empty", int'(bus.empty), 1);
      op(1, 8'hD0, 1, -1);
      chk("empty_rw_udf", int'(bus.underflow), 1);
      chk("empty_rw_count", int'(bus.count), 1);
      chk("empty_rw_valid", int'(bus.rd_valid), 0);
      op(0, 0, 0, -1, 1'b1);

      // full + both in OVERWRITE
      for (int i = 0; i < 4; i++) op(1, 8'hE0 + i, 0, -1);
      op(1, 8'hE4, 1, 8'hE0);
      chk("ovw_both_drop", int'(bus.drop), 0);
      chk("ovw_both_count", int'(bus.count), 4);
      for (int i = 1; i < 5; i++) op(0, 0, 1, 8'hE0 + i);

      // full + both in STREAM
      bus.mode = 1'b0;
      for (int i = 0; i < 4; i++) op(1, 8'h50 + i, 0, -1);
      op(1, 8'h54, 1, 8'h50);
      chk("strm_both_ovf", int'(bus.overflow), 1);
      chk("strm_both_count", int'(bus.count), 3);
      for (int i = 1; i < 4; i++) op(0, 0, 1, 8'h50 + i);

      // clear and reset mid-stream with a read pending
      op(1, 8'hF0, 0, -1); op(1, 8'hF1, 0, -1);
      op(0, 0, 1, -1, 1'b1);
      chk("clr_count", int'(bus.count), 0);
      chk("clr_valid", int'(bus.rd_valid), 0);
      chk("clr_flags", int'({bus.drop, bus.overflow, bus.underflow}), 0);
      chk("clr_rd_data", int'(bus.rd_data), 8'h53);
      op(1, 8'hF2, 0, -1);
      op(0, 0, 1, -1, 1'b0, 1'b1);
      chk("rst2_count", int'(bus.count), 0);
      chk("rst2_valid", int'(bus.rd_valid), 0);
      chk("rst2_rd_data", int'(bus.rd_data), 0);
      chk("rst2_empty", int'(bus.empty), 1);

      op(0, 0, 0, -1); op(0, 0, 0, -1);
      chk("sb_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
